// File: rtl/ram_rr_arb.sv
// Round-robin arbiter sharing one 32-bit single-ported RAM slave among PORTS wishbone-style masters.
// Optional slave watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_rr_arb #(
   parameter int WIDTH   = 10,
   parameter int PORTS   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     wb_clk,
   input  logic                     wb_rst,
   input  logic [PORTS-1:0]         m_cyc,
   input  logic [PORTS-1:0]         m_we,
   input  logic [4*PORTS-1:0]       m_sel,
   input  logic [WIDTH*PORTS-1:0]   m_adr,
   input  logic [32*PORTS-1:0]      m_dat,
   output logic [PORTS-1:0]         m_ack,
   output logic [32*PORTS-1:0]      m_rdt,
   output logic                     x_cyc,
   output logic                     x_we,
   output logic [3:0]               x_sel,
   output logic [WIDTH-1:0]         x_adr,
   output logic [31:0]              x_dat,
   input  logic                     x_ack,
   input  logic [31:0]              x_rdt,
   output logic                     err
);
   localparam int GW = $clog2(PORTS);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           r_state;
   logic [GW-1:0]    r_g;
   logic [GW-1:0]    r_last;
   logic [GW-1:0]    w_pick;
   logic [GW-1:0]    w_idx;
   logic             w_found;
   logic             w_busy;
   logic             w_to;
   logic             w_cyc_g;
   logic             w_we_g;
   logic [3:0]       w_sel_g;
   logic [WIDTH-1:0] w_adr_g;
   logic [31:0]      w_dat_g;

   assign w_busy = (r_state == S_BUSY);

   // First requester strictly after the previous owner, wrapping.
   always_comb begin
      w_pick  = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 1; k <= PORTS; k++) begin
         w_idx = GW'((int'(r_last) + k) % PORTS);
         if (!w_found && m_cyc[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   always_comb begin
      w_cyc_g = 1'b0;
      w_we_g  = 1'b0;
      w_sel_g = '0;
      w_adr_g = '0;
      w_dat_g = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (r_g == GW'(i)) begin
            w_cyc_g = m_cyc[i];
            w_we_g  = m_we[i];
            w_sel_g = m_sel[4*i +: 4];
            w_adr_g = m_adr[WIDTH*i +: WIDTH];
            w_dat_g = m_dat[32*i +: 32];
         end
      end
   end

   assign x_cyc = w_busy && w_cyc_g && !w_to;
   assign x_we  = w_busy && w_we_g;
   assign x_sel = w_busy ? w_sel_g : '0;
   assign x_adr = w_busy ? w_adr_g : '0;
   assign x_dat = (w_busy && w_we_g) ? w_dat_g : '0;

   for (genvar i = 0; i < PORTS; i++) begin : g_lane
      assign m_ack[i]          = w_busy && (r_g == GW'(i)) && (x_ack || w_to);
      assign m_rdt[32*i +: 32] = (w_busy && (r_g == GW'(i)) && !m_we[i] && !w_to) ? x_rdt : '0;
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state <= S_IDLE;
         r_g     <= '0;
         r_last  <= GW'(PORTS-1);
      end else begin
         case (r_state)
            S_IDLE: if (w_found) begin
               r_g     <= w_pick;
               r_state <= S_BUSY;
            end
            S_BUSY: if (!w_cyc_g || w_to) begin
               r_state <= S_IDLE;
               r_last  <= r_g;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT+1);

   logic [CW-1:0] r_cnt;
   logic          r_err;

   // Fires on the TIMEOUT-th consecutive BUSY cycle without an ack.
   assign w_to = w_busy && !x_ack && (r_cnt == CW'(TIMEOUT-1));
   assign err  = r_err;

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (!w_busy || x_ack) r_cnt <= '0;
         else                  r_cnt <= r_cnt + CW'(1);
         if (w_to) r_err <= 1'b1;
      end
   end
`else
   logic w_unused_to;

   assign w_unused_to = (TIMEOUT != 0);
   assign w_to        = 1'b0;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ram_rr_arb.sv
// Self-checking bench for ram_rr_arb: randomized masters against a round-robin reference model.
module tb_ram_rr_arb;
   localparam int W  = 10;
   localparam int P  = 4;
   localparam int TO = 8;

   logic             wb_clk = 1'b0;
   logic             wb_rst;
   logic [P-1:0]     m_cyc, m_we, m_ack;
   logic [4*P-1:0]   m_sel;
   logic [W*P-1:0]   m_adr;
   logic [32*P-1:0]  m_dat, m_rdt;
   logic             x_cyc, x_we, x_ack, err;
   logic [3:0]       x_sel;
   logic [W-1:0]     x_adr;
   logic [31:0]      x_dat, x_rdt;

   int checks = 0;
   int errors = 0;
   int mdl_last;
   logic [32*P-1:0] exp_rdt;

   ram_rr_arb #(.WIDTH(W), .PORTS(P), .TIMEOUT(TO)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat(m_dat),
      .m_ack(m_ack), .m_rdt(m_rdt),
      .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel), .x_adr(x_adr), .x_dat(x_dat),
      .x_ack(x_ack), .x_rdt(x_rdt), .err(err)
   );

   always #5 wb_clk = ~wb_clk;

   initial begin
      #400000;
      $display("FAIL watchdog sim time exceeded");
      $fatal(1);
   end

   // Reference arbitration rule: nearest requester above last, wrapping.
   function automatic int exp_grant(input int last, input logic [P-1:0] mask);
      for (int k = 1; k <= P; k++)
         if (mask[(last+k)%P]) return (last+k)%P;
      return -1;
   endfunction

   task automatic tick;
      @(posedge wb_clk);
      #1;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         tick();
         #1;
         if (x_cyc) ok = 1'b1;
      end
   endtask

   task automatic rand_lanes;
      for (int i = 0; i < P; i++) begin
         m_adr[i*W +: W]   = W'($urandom);
         m_we[i]           = 1'($urandom);
         m_sel[i*4 +: 4]   = 4'($urandom);
         m_dat[i*32 +: 32] = $urandom;
      end
   endtask

   task automatic test_reset;
      wb_rst = 1'b1; m_cyc = '1; rand_lanes(); x_ack = 1'b1; x_rdt = $urandom;
      repeat (2) tick();
      #1;
      checks++; if (x_cyc !== 1'b0) begin errors++; $display("FAIL rst_xcyc got %h exp 0", x_cyc); end
      checks++; if (m_ack !== '0) begin errors++; $display("FAIL rst_mack got %h exp 0", m_ack); end
      checks++; if (m_rdt !== '0) begin errors++; $display("FAIL rst_mrdt got %h exp 0", m_rdt); end
      checks++; if ({x_we, x_sel, x_adr, x_dat} !== '0) begin errors++; $display("FAIL rst_xfields got %h exp 0", {x_we, x_sel, x_adr, x_dat}); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %h exp 0", err); end
      m_cyc = '0; x_ack = 1'b0;
      #2 wb_rst = 1'b0;
      mdl_last = P-1;
   endtask

   task automatic test_round_robin;
      bit ok;
      int e;
      rand_lanes(); m_cyc = '1;
      for (int n = 0; n < 5; n++) begin
         e = n % P;
         wait_grant(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rr_grant_wait n=%0d got none exp grant", n); end
         checks++; if (exp_grant(mdl_last, m_cyc) !== e) begin errors++; $display("FAIL rr_model n=%0d got %0d exp %0d", n, exp_grant(mdl_last, m_cyc), e); end
         checks++; if (x_adr !== m_adr[e*W +: W]) begin errors++; $display("FAIL rr_xadr n=%0d got %h exp %h", n, x_adr, m_adr[e*W +: W]); end
         checks++; if (x_dat !== (m_we[e] ? m_dat[e*32 +: 32] : 32'h0)) begin errors++; $display("FAIL rr_xdat n=%0d got %h", n, x_dat); end
         x_ack = 1'b1; x_rdt = $urandom;
         #1;
         checks++; if (m_ack !== P'(1 << e)) begin errors++; $display("FAIL rr_mack n=%0d got %b exp %b", n, m_ack, P'(1 << e)); end
         tick();
         x_ack = 1'b0; m_cyc[e] = 1'b0;
         #1;
         checks++; if (x_cyc !== 1'b0) begin errors++; $display("FAIL rr_gap_drop n=%0d got %h exp 0", n, x_cyc); end
         tick();
         mdl_last = e;
         if (n == 4) m_cyc = '0; else m_cyc[e] = 1'b1;
         #1;
         checks++; if (x_cyc !== 1'b0) begin errors++; $display("FAIL rr_gap_idle n=%0d got %h exp 0", n, x_cyc); end
      end
      tick();
   endtask

   task automatic test_single_read;
      m_we = '0; m_cyc = 4'b0100; m_adr[2*W +: W] = W'(10'h010); x_ack = 1'b0;
      #1;
      checks++; if (x_cyc !== 1'b0) begin errors++; $display("FAIL rd_latency got %h exp 0", x_cyc); end
      tick(); #1;
      checks++; if (x_cyc !== 1'b1) begin errors++; $display("FAIL rd_xcyc got %h exp 1", x_cyc); end
      checks++; if (x_adr !== W'(10'h010)) begin errors++; $display("FAIL rd_xadr got %h exp 010", x_adr); end
      checks++; if (m_ack !== '0) begin errors++; $display("FAIL rd_early_ack got %b exp 0", m_ack); end
      tick(); tick();
      x_ack = 1'b1; x_rdt = 32'h12345678;
      #1;
      exp_rdt = '0; exp_rdt[2*32 +: 32] = 32'h12345678;
      checks++; if (m_ack !== 4'b0100) begin errors++; $display("FAIL rd_mack got %b exp 0100", m_ack); end
      checks++; if (m_rdt !== exp_rdt) begin errors++; $display("FAIL rd_mrdt got %h exp %h", m_rdt, exp_rdt); end
      tick();
      x_ack = 1'b0; m_cyc = '0;
      #1;
      checks++; if (x_cyc !== 1'b0) begin errors++; $display("FAIL rd_release got %h exp 0", x_cyc); end
      tick();
      mdl_last = 2;
   endtask

   task automatic test_write;
      bit ok;
      rand_lanes();
      m_cyc = 4'b0010; m_we[1] = 1'b1; m_dat[32 +: 32] = 32'hCAFEF00D; m_sel[4 +: 4] = 4'b0011;
      x_rdt = $urandom | 32'h1; x_ack = 1'b0;
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_grant_wait got none exp grant"); end
      for (int c = 0; c < 3; c++) begin
         if (c == 2) x_ack = 1'b1;
         #1;
         checks++; if ({x_we, x_sel, x_dat} !== {1'b1, 4'b0011, 32'hCAFEF00D}) begin errors++; $display("FAIL wr_fields c=%0d got %b %b %h", c, x_we, x_sel, x_dat); end
         checks++; if (m_rdt !== '0) begin errors++; $display("FAIL wr_rdt_iso c=%0d got %h exp 0", c, m_rdt); end
         checks++; if (m_ack !== (c == 2 ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL wr_mack c=%0d got %b", c, m_ack); end
         if (c < 2) tick();
      end
      tick();
      x_ack = 1'b0; m_cyc = '0;
      tick();
      mdl_last = 1;
   endtask

   task automatic test_abort;
      bit ok;
      int e;
      rand_lanes(); m_cyc = 4'b1000; x_ack = 1'b0;
      wait_grant(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ab_grant_wait got none exp grant"); end
      tick();
      m_cyc = 4'b0111;
      #1;
      checks++; if (x_cyc !== 1'b0) begin errors++; $display("FAIL ab_xcyc got %h exp 0", x_cyc); end
      checks++; if (m_ack !== '0) begin errors++; $display("FAIL ab_mack got %b exp 0", m_ack); end
      mdl_last = 3;
      e = exp_grant(mdl_last, m_cyc);
      wait_grant(ok);
      x_ack = 1'b1;
      #1;
      checks++; if (m_ack !== 4'b0001 || e != 0) begin errors++; $display("FAIL ab_next got %b exp 0001", m_ack); end
      tick();
      x_ack = 1'b0; m_cyc = '0;
      tick(); tick();
      mdl_last = 0;
   endtask

   task automatic test_random;
      bit ok;
      int e, d;
      m_cyc = P'($urandom_range(1, (1 << P) - 1)); rand_lanes(); x_ack = 1'b0;
      for (int n = 0; n < 12; n++) begin
         e = exp_grant(mdl_last, m_cyc);
         wait_grant(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rnd_grant_wait n=%0d got none exp grant", n); end
         checks++; if ({x_we, x_sel, x_adr} !== {m_we[e], m_sel[e*4 +: 4], m_adr[e*W +: W]}) begin errors++; $display("FAIL rnd_xfields n=%0d got %h exp master %0d", n, {x_we, x_sel, x_adr}, e); end
         d = $urandom_range(0, 2);
         for (int c = 0; c < d; c++) begin
            tick(); #1;
            checks++; if (m_ack !== '0 || x_cyc !== 1'b1) begin errors++; $display("FAIL rnd_wait n=%0d got ack %b cyc %h", n, m_ack, x_cyc); end
         end
         x_ack = 1'b1; x_rdt = $urandom;
         #1;
         exp_rdt = '0;
         if (!m_we[e]) exp_rdt[e*32 +: 32] = x_rdt;
         checks++; if (m_ack !== P'(1 << e)) begin errors++; $display("FAIL rnd_mack n=%0d got %b exp %b", n, m_ack, P'(1 << e)); end
         checks++; if (m_rdt !== exp_rdt) begin errors++; $display("FAIL rnd_mrdt n=%0d got %h exp %h", n, m_rdt, exp_rdt); end
         tick();
         x_ack = 1'b0; m_cyc[e] = 1'b0;
         tick();
         mdl_last = e;
         if (n == 11) m_cyc = '0;
         else m_cyc = P'($urandom_range(1, (1 << P) - 1));
         rand_lanes();
      end
      tick();
   endtask

   task automatic test_async_reset;
      bit ok;
      m_cyc = P'($urandom_range(1, (1 << P) - 1)); rand_lanes(); x_ack = 1'b0;
      wait_grant(ok);
      x_ack = 1'b1;
      #1;
      checks++; if (m_ack === '0) begin errors++; $display("FAIL ar_pre_ack got %b exp nonzero", m_ack); end
      wb_rst = 1'b1;
      #1;
      checks++; if (x_cyc !== 1'b0) begin errors++; $display("FAIL ar_xcyc got %h exp 0", x_cyc); end
      checks++; if (m_ack !== '0) begin errors++; $display("FAIL ar_mack got %b exp 0", m_ack); end
      x_ack = 1'b0; m_cyc = '1;
      #1 wb_rst = 1'b0;
      mdl_last = P-1;
      wait_grant(ok);
      x_ack = 1'b1;
      #1;
      checks++; if (m_ack !== P'(1 << exp_grant(mdl_last, m_cyc))) begin errors++; $display("FAIL ar_prio got %b exp 0001", m_ack); end
      tick();
      x_ack = 1'b0; m_cyc = '0;
      tick(); tick();
      mdl_last = 0;
   endtask

   task automatic test_timeout;
`ifdef RAM_ARB_TIMEOUT_EN
      bit ok;
      int e;
      rand_lanes(); m_we = '0; m_cyc = 4'b0110; x_ack = 1'b0; x_rdt = $urandom | 32'h1;
      e = exp_grant(mdl_last, m_cyc);
      wait_grant(ok);
      for (int c = 1; c < TO; c++) begin
         checks++; if (m_ack !== '0 || err !== 1'b0) begin errors++; $display("FAIL to_early c=%0d got ack %b err %h", c, m_ack, err); end
         tick(); #1;
      end
      checks++; if (m_ack !== P'(1 << e)) begin errors++; $display("FAIL to_mack got %b exp %b", m_ack, P'(1 << e)); end
      checks++; if (m_rdt !== '0 || x_cyc !== 1'b0) begin errors++; $display("FAIL to_rdt_cyc got %h %h exp 0", m_rdt, x_cyc); end
      tick(); #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %h exp 1", err); end
      mdl_last = e;
      e = exp_grant(mdl_last, m_cyc);
      wait_grant(ok);
      x_ack = 1'b1;
      #1;
      checks++; if (m_ack !== P'(1 << e)) begin errors++; $display("FAIL to_next got %b exp %b", m_ack, P'(1 << e)); end
      tick();
      x_ack = 1'b0; m_cyc = '0;
      tick(); tick(); #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky got %h exp 1", err); end
      mdl_last = e;
`else
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied got %h exp 0", err); end
`endif
   endtask

   initial begin
      m_cyc = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
      x_ack = 1'b0; x_rdt = '0; wb_rst = 1'b1;
      test_reset();
      test_round_robin();
      test_single_read();
      test_write();
      test_abort();
      test_random();
      test_async_reset();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_rr_arb.md
# ram_rr_arb

Registered round-robin arbiter that shares one single-ported 32-bit RAM slave among PORTS wishbone-style masters (cyc/we/sel/adr/dat/ack/rdt). It sits between the DSP engines, the CPU data port and the shared coefficient/sample RAM. It replaces fixed-priority sharing with fair rotation, and has an optional watchdog for slaves that never acknowledge.

## Interface
- WIDTH, 10: word-address width of the RAM.
- PORTS, 4: number of masters (2..8).
- TIMEOUT, 255: watchdog limit in cycles; only used with RAM_ARB_TIMEOUT_EN.
- wb_clk  in  1  system clock; all state on rising edge.
- wb_rst  in  1  reset, asynchronous, active-high.
- m_cyc  in  PORTS  per-master cycle request; bit i = master i.
- m_we  in  PORTS  per-master write enable.
- m_sel  in  4*PORTS  byte selects; master i at [4i+3:4i].
- m_adr  in  WIDTH*PORTS  word addresses; master i at [WIDTH*i+WIDTH-1:WIDTH*i].
- m_dat  in  32*PORTS  write data; master i at [32i+31:32i].
- m_ack  out  PORTS  per-master acknowledge.
- m_rdt  out  32*PORTS  per-master read data.
- x_cyc, x_we  out  1  slave cycle and write enable.
- x_sel  out  4; x_adr out WIDTH; x_dat out 32  slave request fields.
- x_ack  in  1; x_rdt in 32  slave acknowledge and read data.
- err  out  1  sticky timeout flag; constant 0 without RAM_ARB_TIMEOUT_EN.

## Operation
- State: IDLE or BUSY. Registered grant index `g` and round-robin pointer `last` (index of the most recent owner).
- Reset: IDLE, no grant, `last`=PORTS-1 (master 0 has first priority), err=0. All outputs 0.
- IDLE: if any m_cyc is set at the clock edge, grant the first requester searching upward from `last`+1 with wrap (modulo PORTS). Go to BUSY. Otherwise stay in IDLE.
- BUSY: x_cyc=m_cyc[g]. x_we, x_sel and x_adr come from master g. x_dat=m_dat[g] when m_we[g] is set, else 0.
- m_ack[g]=x_ack while BUSY. m_rdt[g]=x_rdt when BUSY and !m_we[g]. All non-granted m_ack and m_rdt lanes are 0.
- Release: at an edge in BUSY where m_cyc[g]=0, go to IDLE and set `last`=g. This applies whether or not an ack was seen; a drop before ack aborts the cycle.
- A master that holds cyc across several acks keeps the grant. This is intentional, for locked read-modify-write.
- Requests from non-granted masters are ignored until they win arbitration. Their m_ack stays 0.
- Outside BUSY, all x_* outputs are 0.

## Timing
- Grant latency: m_cyc rises before edge k, so BUSY starts at edge k and x_cyc is high in cycle k..k+1. This is one cycle of arbitration latency.
- Ack and read data pass combinationally from slave to master, with zero added latency.
- Release: m_cyc[g] is low at edge r, so IDLE holds for cycle r..r+1. The next grant happens at edge r+1.
- x_cyc is therefore low for at least one full cycle between owners, so the slave always sees a cycle boundary.
- Simultaneous requests in IDLE: the nearest index above `last` (with wrap) wins. With all PORTS requesting continuously, the grant order is 0,1,…,PORTS-1,0.
- Reset asserted mid-transaction: grant drops and x_cyc falls immediately (asynchronously). The slave transfer is abandoned.

## Configuration
- RAM_ARB_TIMEOUT_EN defined:
  - A counter clears on entering BUSY and on each x_ack, and increments each BUSY cycle without x_ack.
  - When it reaches TIMEOUT, the arbiter drives m_ack[g]=1 with m_rdt[g]=0 for one cycle and forces x_cyc=0 in that same cycle.
  - It then sets err (sticky until reset) and returns to IDLE with `last`=g, regardless of m_cyc[g].
- Not defined: no counter, err is tied to 0, and a hung slave stalls its owner indefinitely.

## Test plan
- Reset then single read: master 2 reads adr 0x010 while the slave acks 2 cycles after x_cyc with x_rdt=0x12345678. Expect x_cyc one cycle after m_cyc, m_ack[2] coincident with x_ack, m_rdt lane 2=0x12345678, all other lanes 0.
- All 4 masters hold cyc, each drops cyc on ack. Expect grant order 0,1,2,3,0 and one idle x_cyc cycle between each pair.
- Write isolation: master 1 writes 0xCAFEF00D with sel=4'b0011. Expect x_dat=0xCAFEF00D, x_sel=0011, x_we=1, and m_rdt lane 1=0 throughout.
- Abort: master 3 drops cyc before any ack. Expect x_cyc low at the next cycle and the next grant to go to master 0.
- Async reset asserted mid-BUSY: x_cyc and all m_ack fall without a clock edge. After reset release, master 0 has priority.
- With RAM_ARB_TIMEOUT_EN and TIMEOUT=8, the slave never acks. Expect m_ack[g]=1 with m_rdt=0 on the 8th BUSY cycle, err=1 sticky, and the next master granted afterwards.
